acc_proc_core: RTL and testbench
================================

Name: acc_proc_core

Overview:
- Clocked, parametrised successor to the 8-register combinational accumulator processor.
- Executes one instruction word at a time, accepted through a valid/ready handshake.
- Register file is NREG×DATA_W; register 0 (A) is the accumulator.
- IN and OUT become handshaked streams; ALU gains SUB/AND/XOR plus carry and zero flags.
- Register contents are observed through a debug read port instead of one output port per register.

Parameters:
- DATA_W, 8: datapath and register width.
- NREG, 8: register count; power of two, ≥4. REG_AW = log2(NREG).
- INSTR_W, derived = 2 + 2*REG_AW (8 for defaults): instruction width; not user-overridable.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- instr, in, INSTR_W: instruction {op[1:0], f1[REG_AW-1:0], f2[REG_AW-1:0]}, MSB first.
- instr_valid, in, 1: instr is valid.
- instr_ready, out, 1: core can accept an instruction.
- in_data, in, DATA_W: IN operand stream.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: core is consuming in_data.
- out_data, out, DATA_W: OUT result stream.
- out_valid, out, 1: out_data is valid.
- out_ready, in, 1: downstream accepts out_data.
- dbg_addr, in, REG_AW: debug register select.
- dbg_data, out, DATA_W: combinational read of reg[dbg_addr].
- carry, out, 1: carry/borrow from the last ALU op.
- zero, out, 1: last ALU result equalled 0.

Behaviour:
- Reset (async assert, sync release): all registers 0; carry=0, zero=0, out_valid=0, out_data=0, state=IDLE.
- Decode:
  - op=00 IN: f2 is the destination; f1 is ignored.
  - op=10 MOV: f1 is the destination, f2 the source.
  - op=01 ALU: A <= A op reg[f2]; f1[1:0] selects 11 ADD, 10 SUB (A−src), 01 AND, 00 XOR.
  - op=11 OUT: f2 is the source.
- FSM states: IDLE, WAIT_IN, WAIT_OUT. instr_ready=1 only in IDLE; in_ready=1 only in WAIT_IN.
- IDLE, on instr_valid&&instr_ready:
  - MOV/ALU commit on that same edge; stay IDLE. Throughput is 1 instr/cycle.
  - IN: latch destination; go WAIT_IN.
  - OUT: out_data<=reg[f2], out_valid<=1; go WAIT_OUT.
- WAIT_IN: on in_valid, write in_data to the latched destination; go IDLE. in_data is never sampled outside WAIT_IN.
- WAIT_OUT: out_valid and out_data are held stable while out_ready=0. On out_ready, out_valid<=0; go IDLE.
  - The earliest next instruction is accepted on the cycle after the out handshake.
- ALU arithmetic is DATA_W-bit modulo.
  - ADD: carry = bit DATA_W of the sum.
  - SUB: carry = 1 when a borrow occurs (A < src).
  - AND/XOR: carry <= 0.
  - zero updates on every ALU op. MOV/IN/OUT leave both flags unchanged.
- Source-equals-destination (MOV A,A; ADD A) reads the pre-edge value: ADD A doubles A.
- dbg_data reflects the register state after the last edge; there is no write-through.
- Reset mid-WAIT_IN or mid-WAIT_OUT aborts immediately: no register write, out_valid drops asynchronously.
- Instruction with op=01 and f1[REG_AW-1:2] ≠ all-ones: still executes per f1[1:0]. This is documented, not trapped.

Decomposition:
- Package acc_proc_pkg holds:
  - opcode constants OP_IN=2'b00, OP_ALU=2'b01, OP_MOV=2'b10, OP_OUT=2'b11;
  - ALU selects ALU_ADD=2'b11, ALU_SUB=2'b10, ALU_AND=2'b01, ALU_XOR=2'b00;
  - state encoding.
- One sub-module, acc_proc_alu: combinational; inputs a, b, sel; outputs result, carry, zero; parametrised by DATA_W.

Test Plan:
- Tripling program with defaults, in_data=24:
  - IN A 00111000 → A=24; MOV B,A 10001000 → B=24.
  - ADD A 01111000 → A=48; ADD B 01111001 → A=72.
  - OUT A 11111000 → out_valid with out_data=72, carry=0, zero=0.
- Overflow: A=200, ADD A → A=144, carry=1. Then SUB with B=144 → A=0, zero=1, carry=0. Then SUB with B=1 → A=255, carry=1.
- Backpressure: OUT A with out_ready low for 5 cycles → out_valid held and out_data stable throughout, instr_ready=0; on out_ready=1, complete and accept the next MOV on the following cycle.
- Input stall: IN C with in_valid low for 4 cycles → in_ready=1 and C unchanged while waiting; on in_valid with data 0x5A → C=0x5A, instr_ready returns.
- Reset mid-WAIT_IN: rst_n=0 asynchronously → all regs 0, state IDLE, in_ready=0, no write on release.
- Parameter sweep DATA_W=16, NREG=16, INSTR_W=10: ADD 0xFFFF+0x0001 → A=0, carry=1, zero=1; dbg_addr=15 reads reg 15.

Source files
------------

// File: rtl/acc_proc_pkg.sv
// Shared opcode, ALU-select and FSM-state definitions for the clocked
// accumulator processor core and its ALU.
package acc_proc_pkg;

  localparam logic [1:0] OP_IN  = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b11;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_IN  = 2'b01,
    ST_WAIT_OUT = 2'b10
  } state_e;

endpackage

// File: rtl/acc_proc_alu.sv
// Combinational ALU: ADD/SUB/AND/XOR with carry (borrow on SUB) and zero flag.
module acc_proc_alu
  import acc_proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // The extra MSB of the difference is set exactly when a < b (borrow).
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Result and carry selection
  always_comb begin
    result = a ^ b;
    carry  = 1'b0;
    case (sel)
      ALU_ADD: begin
        result = sum_s[DATA_W-1:0];
        carry  = sum_s[DATA_W];
      end
      ALU_SUB: begin
        result = diff_s[DATA_W-1:0];
        carry  = diff_s[DATA_W];
      end
      ALU_AND: begin
        result = a & b;
        carry  = 1'b0;
      end
      ALU_XOR: begin
        result = a ^ b;
        carry  = 1'b0;
      end
      default: begin
        result = a ^ b;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == {DATA_W{1'b0}});

endmodule

// File: rtl/acc_proc_core.sv
// Clocked accumulator processor: one instruction per valid/ready handshake,
// handshaked IN/OUT streams, NREG x DATA_W register file with debug read port.
module acc_proc_core
  import acc_proc_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREG    = 8,
  localparam int REG_AW  = $clog2(NREG),
  localparam int INSTR_W = 2 + 2 * REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               carry,
  output logic               zero
);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [DATA_W-1:0]   regs_r [NREG];
  logic [REG_AW-1:0]   dest_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_valid_r;
  logic                carry_r;
  logic                zero_r;
  logic [1:0]          op_s;
  logic [REG_AW-1:0]   f1_s;
  logic [REG_AW-1:0]   f2_s;
  logic [DATA_W-1:0]   alu_result_s;
  logic                alu_carry_s;
  logic                alu_zero_s;
  logic                instr_ready_s;
  logic                in_ready_s;

  assign op_s = instr[INSTR_W-1 -: 2];
  assign f1_s = instr[2*REG_AW-1 -: REG_AW];
  assign f2_s = instr[REG_AW-1:0];

  // Upper f1 bits are deliberately ignored for ALU ops; only f1[1:0] selects.
  acc_proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (regs_r[0]),
    .b      (regs_r[f2_s]),
    .sel    (f1_s[1:0]),
    .result (alu_result_s),
    .carry  (alu_carry_s),
    .zero   (alu_zero_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid && (op_s == OP_IN)) begin
          state_nxt_s = ST_WAIT_IN;
        end else if (instr_valid && (op_s == OP_OUT)) begin
          state_nxt_s = ST_WAIT_OUT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_IN;
        end
      end
      ST_WAIT_OUT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM handshake outputs
  always_comb begin
    instr_ready_s = 1'b0;
    in_ready_s    = 1'b0;
    case (state_r)
      ST_IDLE:     instr_ready_s = 1'b1;
      ST_WAIT_IN:  in_ready_s    = 1'b1;
      ST_WAIT_OUT: instr_ready_s = 1'b0;
      default: begin
        instr_ready_s = 1'b0;
        in_ready_s    = 1'b0;
      end
    endcase
  end

  // Datapath: register file, flags and output stream; reads see pre-edge values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      dest_r      <= {REG_AW{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            case (op_s)
              OP_MOV: regs_r[f1_s] <= regs_r[f2_s];
              OP_ALU: begin
                regs_r[0] <= alu_result_s;
                carry_r   <= alu_carry_s;
                zero_r    <= alu_zero_s;
              end
              OP_IN:  dest_r <= f2_s;
              OP_OUT: begin
                out_data_r  <= regs_r[f2_s];
                out_valid_r <= 1'b1;
              end
              default: dest_r <= dest_r;
            endcase
          end
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            regs_r[dest_r] <= in_data;
          end
        end
        ST_WAIT_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign instr_ready = instr_ready_s;
  assign in_ready    = in_ready_s;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign carry       = carry_r;
  assign zero        = zero_r;
  assign dbg_data    = regs_r[dbg_addr];

endmodule

// File: tb/tb_acc_proc_core.sv
// Self-checking bench for acc_proc_core: directed scenarios plus a random
// instruction stream compared against an arithmetic reference model.
`timescale 1ns/100ps
module tb_acc_proc_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic        carry;
  logic        zero;

  logic [9:0]  w_instr;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [15:0] w_in_data;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_out_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [3:0]  w_dbg_addr;
  logic [15:0] w_dbg_data;
  logic        w_carry;
  logic        w_zero;

  int checks = 0;
  int failures = 0;
  int m [8];
  int m_c;
  int m_z;

  always #10 clk = ~clk;

  acc_proc_core dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .carry(carry), .zero(zero)
  );

  acc_proc_core #(.DATA_W(16), .NREG(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .instr(w_instr), .instr_valid(w_instr_valid),
    .instr_ready(w_instr_ready), .in_data(w_in_data), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .out_data(w_out_data), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data),
    .carry(w_carry), .zero(w_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input int exp);
    dbg_addr = 3'(idx);
    #0.1;
    check(tag, {24'd0, dbg_data}, 32'(exp));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_reg($sformatf("%s_r%0d", tag, i), i, m[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = 0;
    m_c = 0;
    m_z = 0;
  endtask

  task automatic model_alu(input int sel, input int src);
    int a;
    int b;
    int s;
    a = m[0];
    b = m[src];
    case (sel)
      3: begin s = a + b; m[0] = s % 256; m_c = (s > 255) ? 1 : 0; end
      2: begin m[0] = (a - b + 256) % 256; m_c = (a < b) ? 1 : 0; end
      1: begin m[0] = a & b; m_c = 0; end
      default: begin m[0] = a ^ b; m_c = 0; end
    endcase
    m_z = (m[0] == 0) ? 1 : 0;
  endtask

  // Issue one instruction, complete its IN/OUT handshake with `stall` idle cycles.
  task automatic do_instr(input logic [7:0] ins, input logic [7:0] din, input int stall);
    logic [1:0] op;
    logic [2:0] f1;
    logic [2:0] f2;
    int         exp_out;
    op = ins[7:6];
    f1 = ins[5:3];
    f2 = ins[2:0];
    @(negedge clk);
    check("instr_ready_idle", {31'd0, instr_ready}, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    in_valid    = 1'($urandom % 2);
    in_data     = 8'($urandom);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    in_valid    = 1'b0;
    case (op)
      2'b10: m[f1] = m[f2];
      2'b01: model_alu(int'(f1[1:0]), int'(f2));
      2'b00: begin
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        check("instr_ready_wait_in", {31'd0, instr_ready}, 32'd0);
        repeat (stall) begin
          @(posedge clk);
          #1;
          check("in_ready_stall", {31'd0, in_ready}, 32'd1);
          check_reg("dest_unchanged", int'(f2), m[f2]);
        end
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        m[f2] = int'(din);
        check("instr_ready_after_in", {31'd0, instr_ready}, 32'd1);
        check("in_ready_after_in", {31'd0, in_ready}, 32'd0);
      end
      2'b11: begin
        exp_out = m[f2];
        check("out_valid_set", {31'd0, out_valid}, 32'd1);
        check("out_data", {24'd0, out_data}, 32'(exp_out));
        check("instr_ready_wait_out", {31'd0, instr_ready}, 32'd0);
        repeat (stall) begin
          @(posedge clk);
          #1;
          check("out_valid_held", {31'd0, out_valid}, 32'd1);
          check("out_data_held", {24'd0, out_data}, 32'(exp_out));
          check("instr_ready_held", {31'd0, instr_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_clear", {31'd0, out_valid}, 32'd0);
        check("instr_ready_after_out", {31'd0, instr_ready}, 32'd1);
      end
      default: m[0] = m[0];
    endcase
    check("carry", {31'd0, carry}, 32'(m_c));
    check("zero", {31'd0, zero}, 32'(m_z));
  endtask

  task automatic drive16(input logic [9:0] ins, input logic [15:0] din);
    @(negedge clk);
    w_instr       = ins;
    w_instr_valid = 1'b1;
    @(posedge clk);
    #1;
    w_instr_valid = 1'b0;
    if (ins[9:8] == 2'b00) begin
      @(negedge clk);
      w_in_data  = din;
      w_in_valid = 1'b1;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rins;
    rst_n = 1'b0;
    instr = 8'd0; instr_valid = 1'b0; in_data = 8'd0; in_valid = 1'b0;
    out_ready = 1'b0; dbg_addr = 3'd0;
    w_instr = 10'd0; w_instr_valid = 1'b0; w_in_data = 16'd0; w_in_valid = 1'b0;
    w_out_ready = 1'b0; w_dbg_addr = 4'd0;
    model_reset();

    // Reset state
    #25;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_instr_ready", {31'd0, instr_ready}, 32'd1);

    // Tripling program
    do_instr(8'b00111000, 8'd24, 0); check_reg("trip_in_a", 0, 24);
    do_instr(8'b10001000, 8'd0, 0);  check_reg("trip_mov_b", 1, 24);
    do_instr(8'b01111000, 8'd0, 0);  check_reg("trip_add_a", 0, 48);
    do_instr(8'b01111001, 8'd0, 0);  check_reg("trip_add_b", 0, 72);
    do_instr(8'b11111000, 8'd0, 0);
    check("trip_out_data", {24'd0, out_data}, 32'd72);
    check("trip_carry", {31'd0, carry}, 32'd0);
    check("trip_zero", {31'd0, zero}, 32'd0);

    // Overflow and borrow
    do_instr(8'b00111000, 8'd200, 0);
    do_instr(8'b01111000, 8'd0, 0);
    check_reg("ovf_a", 0, 144);
    check("ovf_carry", {31'd0, carry}, 32'd1);
    do_instr(8'b00111001, 8'd144, 0);
    do_instr(8'b01110001, 8'd0, 0);
    check_reg("sub_zero_a", 0, 0);
    check("sub_zero_flag", {31'd0, zero}, 32'd1);
    check("sub_zero_carry", {31'd0, carry}, 32'd0);
    do_instr(8'b00111001, 8'd1, 0);
    do_instr(8'b01110001, 8'd0, 0);
    check_reg("borrow_a", 0, 255);
    check("borrow_carry", {31'd0, carry}, 32'd1);

    // Output backpressure, then a MOV on the cycle after the handshake
    do_instr(8'b11000000, 8'd0, 5);
    do_instr(8'b10010000, 8'd0, 0);
    check_reg("bp_mov_c", 2, 255);

    // Input stall
    do_instr(8'b00000010, 8'h5A, 4);
    check_reg("stall_c", 2, 8'h5A);
    check_regs("directed");

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      rins = 8'($urandom);
      do_instr(rins, 8'($urandom), int'($urandom_range(0, 3)));
      check_regs("rand");
    end

    // Reset while waiting for input
    do_instr(8'b00000000, 8'h33, 0);
    @(negedge clk);
    instr = 8'b00000010; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("rwi_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_data = 8'hA5; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rwi_in_ready_rst", {31'd0, in_ready}, 32'd0);
    check("rwi_instr_ready_rst", {31'd0, instr_ready}, 32'd1);
    check_regs("rwi");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_reg("rwi_no_write", 2, 0);
    check("rwi_in_ready_rel", {31'd0, in_ready}, 32'd0);

    // Reset while waiting for output acceptance
    do_instr(8'b00000001, 8'h77, 0);
    @(negedge clk);
    instr = 8'b11000001; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("rwo_out_valid", {31'd0, out_valid}, 32'd1);
    check("rwo_out_data", {24'd0, out_data}, 32'h77);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rwo_out_valid_rst", {31'd0, out_valid}, 32'd0);
    check("rwo_out_data_rst", {24'd0, out_data}, 32'd0);
    check("rwo_instr_ready_rst", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs("rwo");

    // 16-bit, 16-register configuration
    drive16({2'b00, 4'd0, 4'd0}, 16'hFFFF);
    drive16({2'b00, 4'd0, 4'd1}, 16'h0001);
    drive16({2'b01, 4'b1111, 4'd1}, 16'h0000);
    w_dbg_addr = 4'd0;
    #0.1;
    check("w16_add_a", {16'd0, w_dbg_data}, 32'd0);
    check("w16_carry", {31'd0, w_carry}, 32'd1);
    check("w16_zero", {31'd0, w_zero}, 32'd1);
    drive16({2'b00, 4'd0, 4'd15}, 16'hBEEF);
    w_dbg_addr = 4'd15;
    #0.1;
    check("w16_reg15", {16'd0, w_dbg_data}, 32'hBEEF);
    w_dbg_addr = 4'd1;
    #0.1;
    check("w16_reg1", {16'd0, w_dbg_data}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
